// File: rtl/tournament_predictor_if.sv
// Fetch-side bundle for the tournament direction predictor:
// prediction request/response plus branch resolution feedback.
interface tournament_predictor_if #(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 8
);
    logic [XLEN-1:0]       PC;
    logic                  cond_branch;
    logic                  predict_enable;
    logic                  tournament_taken;
    logic [INDEX_BITS-1:0] predict_ghr;
    logic                  result_enable;
    logic [XLEN-1:0]       result_PC;
    logic                  result_taken;
    logic                  result_mispredict;
    logic [INDEX_BITS-1:0] result_ghr;

    modport master (
        output PC,
        output cond_branch,
        output predict_enable,
        input  tournament_taken,
        input  predict_ghr,
        output result_enable,
        output result_PC,
        output result_taken,
        output result_mispredict,
        output result_ghr
    );

    modport slave (
        input  PC,
        input  cond_branch,
        input  predict_enable,
        output tournament_taken,
        output predict_ghr,
        input  result_enable,
        input  result_PC,
        input  result_taken,
        input  result_mispredict,
        input  result_ghr
    );
endinterface

// File: rtl/tournament_predictor.sv
// Tournament direction predictor: bimodal + gshare tables with a
// per-PC chooser and a speculative, recoverable global history.
module tournament_predictor #(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 8
) (
    input logic clock,
    input logic reset,
    tournament_predictor_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [1:0]            ctr_t;

    ctr_t local_tbl   [ENTRIES];
    ctr_t global_tbl  [ENTRIES];
    ctr_t chooser_tbl [ENTRIES];

    idx_t ghr;
    idx_t li;
    idx_t gi;
    idx_t rli;
    idx_t rgi;

    logic lp;
    logic gp;
    logic taken;
    logic rlp;
    logic rgp;
    logic recover;
    logic shift;
    logic unused_bits;

    function automatic ctr_t sat_step(input ctr_t c, input logic up);
        ctr_t n;
        n = c;
        if (up) begin
            if (c != 2'd3) n = c + 2'd1;
        end else begin
            if (c != 2'd0) n = c - 2'd1;
        end
        return n;
    endfunction

    assign li  = bus.PC[INDEX_BITS+1:2];
    assign gi  = li ^ ghr;
    assign rli = bus.result_PC[INDEX_BITS+1:2];
    assign rgi = rli ^ bus.result_ghr;

    assign lp    = local_tbl[li][1];
    assign gp    = global_tbl[gi][1];
    assign taken = reset & bus.cond_branch &
                   (chooser_tbl[li][1] ? gp : lp);

    assign rlp = local_tbl[rli][1];
    assign rgp = global_tbl[rgi][1];

    assign bus.tournament_taken = taken;
    assign bus.predict_ghr      = reset ? ghr : '0;

    // A resolved mispredict overrides any same-cycle speculative shift.
    assign recover = bus.result_enable & bus.result_mispredict;
    assign shift   = ~recover & bus.predict_enable & bus.cond_branch;

    assign unused_bits = ^{bus.PC[XLEN-1:INDEX_BITS+2],
                           bus.PC[1:0],
                           bus.result_PC[XLEN-1:INDEX_BITS+2],
                           bus.result_PC[1:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                local_tbl[i]   <= 2'b01;
                global_tbl[i]  <= 2'b01;
                chooser_tbl[i] <= 2'b01;
            end
        end else if (bus.result_enable) begin
            local_tbl[rli]  <= sat_step(local_tbl[rli], bus.result_taken);
            global_tbl[rgi] <= sat_step(global_tbl[rgi], bus.result_taken);
            // Chooser only learns when the two components disagreed.
            if (rlp != rgp) begin
                chooser_tbl[rli] <= sat_step(chooser_tbl[rli],
                                             rgp == bus.result_taken);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ghr <= '0;
        end else begin
            unique case (1'b1)
                recover: ghr <= {bus.result_ghr[INDEX_BITS-2:0],
                                 bus.result_taken};
                shift:   ghr <= {ghr[INDEX_BITS-2:0], taken};
                default: ghr <= ghr;
            endcase
        end
    end
endmodule

// File: tb/tb_tournament_predictor.sv
// Directed + randomized bench for tournament_predictor against
// a table-level behavioural model.
module tb_tournament_predictor;
    localparam int XLEN = 32;
    localparam int IB   = 8;
    localparam int N    = 256;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    int m_loc [N];
    int m_glb [N];
    int m_ch  [N];
    int m_ghr;
    bit m_rst;

    tournament_predictor_if #(.XLEN(XLEN), .INDEX_BITS(IB)) bus ();

    tournament_predictor #(.XLEN(XLEN), .INDEX_BITS(IB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int c, input bit up);
        if (up) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic int idx(input logic [31:0] pc);
        return int'(pc / 4) % N;
    endfunction

    function automatic int m_pred();
        int li;
        int gi;
        if (m_rst || !bus.cond_branch) return 0;
        li = idx(bus.PC);
        gi = li ^ m_ghr;
        if (m_ch[li] >= 2) return (m_glb[gi] >= 2) ? 1 : 0;
        return (m_loc[li] >= 2) ? 1 : 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_loc[i] = 1;
            m_glb[i] = 1;
            m_ch[i]  = 1;
        end
        m_ghr = 0;
    endtask

    task automatic m_clock();
        int p, rli, rgi;
        bit rlp, rgp, t;
        if (m_rst) return;
        p = m_pred();
        if (bus.result_enable) begin
            t   = bus.result_taken;
            rli = idx(bus.result_PC);
            rgi = rli ^ int'(bus.result_ghr);
            rlp = m_loc[rli] >= 2;
            rgp = m_glb[rgi] >= 2;
            if (rlp != rgp) m_ch[rli] = sat(m_ch[rli], rgp == t);
            m_loc[rli] = sat(m_loc[rli], t);
            m_glb[rgi] = sat(m_glb[rgi], t);
        end
        if (bus.result_enable && bus.result_mispredict)
            m_ghr = (int'(bus.result_ghr) * 2 + int'(bus.result_taken)) % N;
        else if (bus.predict_enable && bus.cond_branch)
            m_ghr = (m_ghr * 2 + p) % N;
    endtask

    task automatic predict(input logic [31:0] pc, input bit cond,
                           input bit pe);
        bus.PC             = pc;
        bus.cond_branch    = cond;
        bus.predict_enable = pe;
    endtask

    task automatic resolve(input bit en, input logic [31:0] pc,
                           input bit t, input bit mis,
                           input logic [7:0] g);
        bus.result_enable     = en;
        bus.result_PC         = pc;
        bus.result_taken      = t;
        bus.result_mispredict = mis;
        bus.result_ghr        = g;
    endtask

    task automatic cycle();
        @(negedge clock);
        check("taken", {31'b0, bus.tournament_taken}, m_pred());
        check("ghr", {24'b0, bus.predict_ghr}, m_ghr);
        @(posedge clock);
        m_clock();
        #1;
    endtask

    initial begin
        m_rst = 1;
        m_reset();
        predict(32'h100, 1, 0);
        resolve(0, 0, 0, 0, 0);
        #12;
        check("in_reset_taken", {31'b0, bus.tournament_taken}, 0);
        check("in_reset_ghr", {24'b0, bus.predict_ghr}, 0);
        @(posedge clock);
        #1;
        reset = 1;
        m_rst = 0;

        // reset defaults
        #1 check("rst_taken", {31'b0, bus.tournament_taken}, 0);
        check("rst_ghr", {24'b0, bus.predict_ghr}, 0);
        cycle();
        predict(32'h100, 0, 0);
        #1 check("rst_nocond", {31'b0, bus.tournament_taken}, 0);
        cycle();

        // train 0x100 taken twice
        resolve(1, 32'h100, 1, 0, 8'h00);
        cycle();
        cycle();
        resolve(0, 0, 0, 0, 0);
        predict(32'h100, 1, 0);
        #1 check("trained_taken", {31'b0, bus.tournament_taken}, 1);
        cycle();

        // speculative history 0,0,1 then 1
        predict(32'h300, 1, 1);
        cycle();
        cycle();
        predict(32'h100, 1, 1);
        cycle();
        check("spec_ghr_01", {24'b0, bus.predict_ghr}, 8'h01);
        cycle();
        check("spec_ghr_03", {24'b0, bus.predict_ghr}, 8'h03);
        predict(32'h100, 1, 0);
        cycle();
        check("ghr_hold", {24'b0, bus.predict_ghr}, 8'h03);

        // mispredict recovery beats same-cycle shift
        resolve(1, 32'h800, 1, 1, 8'h3F);
        predict(32'h100, 0, 0);
        cycle();
        check("ghr_7f", {24'b0, bus.predict_ghr}, 8'h7F);
        resolve(1, 32'h800, 1, 1, 8'h05);
        predict(32'h100, 1, 1);
        cycle();
        check("recover_0b", {24'b0, bus.predict_ghr}, 8'h0B);

        // chooser training at PC 0x200
        predict(32'h200, 1, 0);
        resolve(1, 32'h200, 0, 1, 8'h80);
        cycle();
        resolve(1, 32'h300, 1, 0, 8'h40);
        cycle();
        check("pre_choose", {31'b0, bus.tournament_taken}, 0);
        resolve(1, 32'h200, 1, 0, 8'h00);
        cycle();
        cycle();
        resolve(0, 0, 0, 0, 0);
        #1 check("choose_global", {31'b0, bus.tournament_taken}, 1);
        check("choose_ghr", {24'b0, bus.predict_ghr}, 0);
        cycle();
        resolve(1, 32'h200, 0, 0, 8'h02);
        cycle();
        resolve(1, 32'h200, 0, 0, 8'h00);
        cycle();
        resolve(0, 0, 0, 0, 0);
        #1 check("chooser_3to2", {31'b0, bus.tournament_taken}, 1);
        cycle();

        // asynchronous reset mid-stream with training active
        predict(32'h100, 1, 1);
        resolve(1, 32'h100, 1, 0, 8'h00);
        #1 check("pre_areset", {31'b0, bus.tournament_taken}, 1);
        #1;
        reset = 0;
        m_rst = 1;
        m_reset();
        #1 check("areset_taken", {31'b0, bus.tournament_taken}, 0);
        check("areset_ghr", {24'b0, bus.predict_ghr}, 0);
        @(posedge clock);
        #1;
        reset = 1;
        m_rst = 0;
        resolve(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            predict($urandom & 32'hFFFF_FFFC, 1, 0);
            #1 check("post_rst_nt", {31'b0, bus.tournament_taken}, 0);
            cycle();
        end

        // randomized traffic over a small index set
        for (int i = 0; i < 600; i++) begin
            predict((32'($urandom_range(0, 15)) << 2) |
                    ($urandom & 32'hFFFF_FC00),
                    ($urandom % 4) != 0, $urandom % 2);
            resolve($urandom % 2,
                    (32'($urandom_range(0, 15)) << 2),
                    $urandom % 2, ($urandom % 4) == 0,
                    8'($urandom));
            if (i == 300) begin
                #2;
                reset = 0;
                m_rst = 1;
                m_reset();
                #1 check("rand_areset", {31'b0, bus.tournament_taken}, 0);
                @(posedge clock);
                #1;
                reset = 1;
                m_rst = 0;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
